// File: rtl/mips_trace_buffer.sv
// Trace buffer for a MIPS core: arms, waits for a trigger PC, then captures
// (pc, alu) samples on every PC change into a first-word-fall-through FIFO.
module mips_trace_buffer #(
  parameter int PC_WIDTH   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic                      stop,
  input  logic [PC_WIDTH-1:0]       trig_pc,
  input  logic [PC_WIDTH-1:0]       pc_in,
  input  logic [DATA_WIDTH-1:0]     alu_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [DATA_WIDTH-1:0]     out_alu,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      busy,
  output logic                      overflow,
  output logic [7:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TRIG = 2'd1,
    S_CAPTURE   = 2'd2
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic   [PC_WIDTH-1:0]            r_last_pc;
  logic   [PC_WIDTH+DATA_WIDTH-1:0] r_mem [DEPTH];
  logic   [AW-1:0]                  r_wptr;
  logic   [AW-1:0]                  r_rptr;
  logic   [CW-1:0]                  r_count;
  logic                             r_overflow;
  logic   [7:0]                     r_drop_cnt;

  logic                             w_busy;
  logic                             w_arm_clear;
  logic                             w_wr_attempt;
  logic                             w_pop;
  logic                             w_full;
  logic                             w_wr;
  logic                             w_drop;
  logic   [PC_WIDTH+DATA_WIDTH-1:0] w_head;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; stop outranks both arm and the trigger match
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (arm && !stop) w_state_nxt = S_WAIT_TRIG;
        else              w_state_nxt = S_IDLE;
      end
      S_WAIT_TRIG: begin
        if (stop)                    w_state_nxt = S_IDLE;
        else if (pc_in == trig_pc)   w_state_nxt = S_CAPTURE;
        else                         w_state_nxt = S_WAIT_TRIG;
      end
      S_CAPTURE: begin
        if (stop) w_state_nxt = S_IDLE;
        else      w_state_nxt = S_CAPTURE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: busy, re-arm flag clear and sample write request
  always_comb begin
    w_busy       = 1'b0;
    w_arm_clear  = 1'b0;
    w_wr_attempt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy      = 1'b0;
        w_arm_clear = arm && !stop;
      end
      S_WAIT_TRIG: begin
        w_busy       = 1'b1;
        w_wr_attempt = !stop && (pc_in == trig_pc);
      end
      S_CAPTURE: begin
        w_busy       = 1'b1;
        w_wr_attempt = !stop && (pc_in != r_last_pc);
      end
      default: begin
        w_busy       = 1'b0;
        w_arm_clear  = 1'b0;
        w_wr_attempt = 1'b0;
      end
    endcase
  end

  // A pop frees the slot the same edge, so a full FIFO still accepts a write
  assign w_pop  = out_valid && out_ready;
  assign w_full = (r_count == CW'(DEPTH));
  assign w_wr   = w_wr_attempt && (!w_full || w_pop);
  assign w_drop = w_wr_attempt && w_full && !w_pop;

  // Sample storage; contents are meaningless once count says so
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {pc_in, alu_in};
    end
  end

  // Pointers, occupancy and dedupe reference
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_last_pc <= '0;
    end else begin
      if (w_wr)         r_wptr    <= r_wptr + AW'(1);
      if (w_pop)        r_rptr    <= r_rptr + AW'(1);
      if (w_wr_attempt) r_last_pc <= pc_in;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow and saturating drop counter, cleared on a fresh arm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_arm_clear) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign w_head    = r_mem[r_rptr];
  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? w_head[PC_WIDTH+DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign out_alu   = out_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign count     = r_count;
  assign busy      = w_busy;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_mips_trace_buffer;
  localparam int PW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst, arm, stop, out_ready;
  logic [PW-1:0] trig_pc, pc_in;
  logic [DW-1:0] alu_in;
  logic          out_valid, busy, overflow;
  logic [PW-1:0] out_pc;
  logic [DW-1:0] out_alu;
  logic [CW-1:0] count;
  logic [7:0]    drop_cnt;

  mips_trace_buffer #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .trig_pc(trig_pc),
    .pc_in(pc_in), .alu_in(alu_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu(out_alu), .count(count), .busy(busy),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: session mode, dedupe PC, FIFO as a queue
  typedef struct packed { logic [PW-1:0] pc; logic [DW-1:0] alu; } samp_t;
  samp_t         mq[$];
  int            m_mode;   // 0 idle, 1 waiting for trigger, 2 capturing
  logic [PW-1:0] m_last;
  logic          m_ov;
  int            m_drop;

  typedef struct {
    logic          a;
    logic [PW-1:0] pc;
    int            exp_count;
    logic          exp_busy;
    logic [PW-1:0] exp_pc;
    logic [DW-1:0] exp_alu;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode = 0;
    m_last = '0;
    m_ov   = 1'b0;
    m_drop = 0;
  endtask

  task automatic model_edge();
    bit    pop, full, attempt;
    samp_t s;
    pop     = (mq.size() != 0) && out_ready;
    full    = (mq.size() == DEPTH);
    attempt = 1'b0;
    if (m_mode == 0) begin
      if (arm && !stop) begin
        m_mode = 1; m_ov = 1'b0; m_drop = 0;
      end
    end else if (stop) begin
      m_mode = 0;
    end else if (m_mode == 1) begin
      if (pc_in == trig_pc) begin
        attempt = 1'b1; m_mode = 2;
      end
    end else if (pc_in != m_last) begin
      attempt = 1'b1;
    end
    if (attempt) m_last = pc_in;
    if (pop) s = mq.pop_front();
    if (attempt) begin
      if (!full || pop) begin
        s.pc = pc_in; s.alu = alu_in;
        mq.push_back(s);
      end else begin
        m_ov = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic compare_model();
    chk("count", 32'(count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("out_pc", 32'(out_pc), (mq.size() != 0) ? 32'(mq[0].pc) : 32'd0);
    chk("out_alu", 32'(out_alu), (mq.size() != 0) ? 32'(mq[0].alu) : 32'd0);
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic step(input logic a, input logic s, input logic [PW-1:0] tp,
                      input logic [PW-1:0] pc, input logic [DW-1:0] alu, input logic rdy);
    arm = a; stop = s; trig_pc = tp; pc_in = pc; alu_in = alu; out_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    arm = 1'b0; stop = 1'b0; out_ready = 1'b0;
    trig_pc = '0; pc_in = '0; alu_in = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
  endtask

  function automatic logic [PW-1:0] pcv(input int i);
    return 16'h0100 + 16'(2 * i);
  endfunction

  function automatic logic [DW-1:0] alv(input logic [PW-1:0] pc);
    return pc ^ 16'h5A5A;
  endfunction

  initial begin
    logic [PW-1:0] drain_exp[8];
    rst = 1'b1;

    // Trigger and dedupe vectors: trig 0x0004, alu = pc*3, no draining
    vt[0] = '{1'b1, 16'h0000, 0, 1'b1, 16'h0000, 16'h0000};
    vt[1] = '{1'b0, 16'h0000, 0, 1'b1, 16'h0000, 16'h0000};
    vt[2] = '{1'b0, 16'h0002, 0, 1'b1, 16'h0000, 16'h0000};
    vt[3] = '{1'b0, 16'h0004, 1, 1'b1, 16'h0004, 16'h000C};
    vt[4] = '{1'b0, 16'h0004, 1, 1'b1, 16'h0004, 16'h000C};
    vt[5] = '{1'b0, 16'h0006, 2, 1'b1, 16'h0004, 16'h000C};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(vt[i].a, 1'b0, 16'h0004, vt[i].pc, 16'(vt[i].pc * 16'd3), 1'b0);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].exp_count));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
      chk($sformatf("vec%0d_pc", i), 32'(out_pc), 32'(vt[i].exp_pc));
      chk($sformatf("vec%0d_alu", i), 32'(out_alu), 32'(vt[i].exp_alu));
    end

    // Overflow: ten distinct PCs into an eight-entry FIFO
    do_reset();
    step(1'b1, 1'b0, pcv(0), 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, pcv(0), pcv(i), alv(pcv(i)), 1'b0);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    chk("ovf_head", 32'(out_pc), 32'(pcv(0)));
    // Full FIFO: push and pop on the same edge
    step(1'b0, 1'b0, pcv(0), pcv(10), alv(pcv(10)), 1'b1);
    chk("fullpp_count", 32'(count), 32'd8);
    chk("fullpp_flag", 32'(overflow), 32'd1);
    chk("fullpp_drop", 32'(drop_cnt), 32'd2);
    step(1'b0, 1'b0, pcv(0), pcv(11), alv(pcv(11)), 1'b0);
    chk("drop3", 32'(drop_cnt), 32'd3);
    step(1'b0, 1'b1, pcv(0), pcv(12), alv(pcv(12)), 1'b0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_count", 32'(count), 32'd8);
    // Re-arm clears flags and keeps contents
    step(1'b1, 1'b0, pcv(0), pcv(13), alv(pcv(13)), 1'b0);
    chk("rearm_flag", 32'(overflow), 32'd0);
    chk("rearm_drop", 32'(drop_cnt), 32'd0);
    chk("rearm_count", 32'(count), 32'd8);
    chk("rearm_busy", 32'(busy), 32'd1);
    step(1'b0, 1'b1, pcv(0), pcv(14), alv(pcv(14)), 1'b0);
    // Drain in idle: entries 1..7 then the PC pushed while full
    for (int k = 0; k < 7; k++) drain_exp[k] = pcv(k + 1);
    drain_exp[7] = pcv(10);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_pc", k), 32'(out_pc), 32'(drain_exp[k]));
      chk($sformatf("drain%0d_alu", k), 32'(out_alu), 32'(alv(drain_exp[k])));
      step(1'b0, 1'b0, pcv(0), 16'h0000, 16'h0000, 1'b1);
    end
    chk("drained_count", 32'(count), 32'd0);
    chk("drained_pc", 32'(out_pc), 32'd0);

    // Stop outranks a trigger match
    do_reset();
    step(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h0020, 16'h0020, 16'h1111, 1'b0);
    chk("stoppri_busy", 32'(busy), 32'd0);
    chk("stoppri_count", 32'(count), 32'd0);
    step(1'b0, 1'b0, 16'h0020, 16'h0020, 16'h2222, 1'b0);
    chk("idle_ignore", 32'(count), 32'd0);

    // Asynchronous reset mid-capture
    do_reset();
    step(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0030, 16'(16'h0030 + 16'(2 * i)), 16'(i), 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 16'h0030, 16'h0030, 16'h0001, 1'b0);
    step(1'b0, 1'b0, 16'h0030, 16'h0032, 16'h0002, 1'b0);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(7) == 0, $urandom_range(15) == 0, 16'($urandom_range(3)),
           16'($urandom_range(5)), 16'($urandom), $urandom_range(3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_trace_buffer.md
MIPS_TRACE_BUFFER -- requirements
Module: mips_trace_buffer

Interface
REQ-001 SHALL take parameter PC_WIDTH, default 16, program-counter sample width.
REQ-002 SHALL take parameter DATA_WIDTH, default 16, ALU-result sample width.
REQ-003 SHALL take parameter DEPTH, default 8, FIFO entries; a power of 2 and >= 2.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1, rising-edge clock shared with the processor.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port arm, input, 1, single-cycle request to start a capture session.
REQ-008 SHALL have port stop, input, 1, single-cycle request to end a capture session.
REQ-009 SHALL have port trig_pc, input, PC_WIDTH, PC value that opens capture.
REQ-010 SHALL have port pc_in, input, PC_WIDTH, processor pc_out sampled each cycle.
REQ-011 SHALL have port alu_in, input, DATA_WIDTH, processor alu_result sampled each cycle.
REQ-012 SHALL have port out_valid, output, 1, FIFO head valid.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts head.
REQ-014 SHALL have port out_pc, output, PC_WIDTH, head PC.
REQ-015 SHALL have port out_alu, output, DATA_WIDTH, head ALU result.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-017 SHALL have port busy, output, 1, high in WAIT_TRIG or CAPTURE.
REQ-018 SHALL have port overflow, output, 1, sticky flag set when a sample was dropped.
REQ-019 SHALL have port drop_cnt, output, 8, count of dropped samples, saturating.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT_TRIG and CAPTURE.
REQ-021 IDLE SHALL move to WAIT_TRIG on arm=1 and stop=0; the same edge SHALL clear overflow and drop_cnt and SHALL keep FIFO contents.
REQ-022 In IDLE, arm=1 with stop=1 SHALL leave the state in IDLE and SHALL clear nothing.
REQ-023 WAIT_TRIG SHALL move to CAPTURE on the edge where pc_in==trig_pc; that sample SHALL be written, and last_pc SHALL be set to pc_in.
REQ-024 In CAPTURE, a sample SHALL be written on every edge where pc_in!=last_pc; last_pc SHALL then update to pc_in, whether the write succeeds or is dropped.
REQ-025 A repeated pc_in (equal to last_pc) SHALL NOT be written.
REQ-026 stop=1 in WAIT_TRIG or CAPTURE SHALL return the FSM to IDLE at that edge; the sample on that edge SHALL NOT be written; stop has priority over the trigger.
REQ-027 arm in WAIT_TRIG or CAPTURE SHALL be ignored.
REQ-028 busy SHALL equal (state != IDLE).
REQ-029 The FIFO SHALL be first-word-fall-through, with out_valid = (count != 0).
REQ-030 A pop SHALL occur when out_valid && out_ready.
REQ-031 A written sample SHALL appear at the head one cycle after its capture edge when the FIFO was empty.
REQ-032 out_pc and out_alu SHALL be 0 whenever out_valid=0.
REQ-033 A write attempt when count==DEPTH with no pop in the same cycle SHALL drop the sample, set overflow, and increment drop_cnt, saturating at 255.
REQ-034 A write and a pop in the same cycle when full SHALL both succeed, with count unchanged and no overflow.
REQ-035 A write when empty SHALL NOT be popped in the same cycle.
REQ-036 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-037 The FIFO SHALL keep draining in IDLE.

Reset
REQ-038 rst=1 SHALL immediately force state IDLE and count 0, with pointers 0, last_pc 0, out_valid 0, out_pc 0, out_alu 0, busy 0, overflow 0 and drop_cnt 0.
REQ-039 Reset asserted mid-capture SHALL discard all FIFO contents, and no partial write SHALL survive.
REQ-040 After rst deasserts, the block SHALL ignore pc_in until arm.

Verification
REQ-041 Trigger and dedupe: arm; trig_pc=0x0004; pc_in sequence 0,2,4,4,6 with alu_in=pc*3; out_ready=0 -> count=2, head (0x0004,0x000C), busy=1.
REQ-042 Overflow: DEPTH=8, capture 10 distinct PCs, out_ready=0 -> count=8, overflow=1, drop_cnt=2, drained order is the first 8 PCs.
REQ-043 Full push and pop: with FIFO full, a new PC and out_ready=1 in the same cycle -> count stays 8, overflow unchanged, new PC is last drained.
REQ-044 Stop priority: stop=1 on the edge where pc_in==trig_pc in WAIT_TRIG -> state IDLE, count unchanged, busy=0.
REQ-045 Async reset: rst pulse mid-capture with count=5 -> out_valid=0 and count=0 before the next clk edge; arm after rst is needed to resume.
REQ-046 Re-arm clear: overflow=1 with drop_cnt=3, then arm in IDLE -> overflow=0 and drop_cnt=0 next cycle, FIFO contents retained.
